// File: rtl/debug_mem_reader_pkg.sv
// Shared types and constants for the data-memory debug read path.
package debug_mem_reader_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_SEND = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int unsigned BYTE_W = 8;

    function automatic int unsigned bytes_per_word(input int unsigned len_data);
        return len_data / BYTE_W;
    endfunction

    // A one-byte word still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debug_mem_reader_word_byte_serializer.sv
// Holds one memory word and presents it byte by byte, MSB first.
module word_byte_serializer
    import debug_mem_reader_pkg::*;
#(
    parameter int unsigned LEN_DATA = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                shift,
    input  logic [LEN_DATA-1:0] word_in,
    output logic [BYTE_W-1:0]   byte_out,
    output logic                last
);

    localparam int unsigned BYTES_PER_WORD = bytes_per_word(LEN_DATA);
    localparam int unsigned CNT_W          = cnt_width(BYTES_PER_WORD);

    logic [LEN_DATA-1:0] shift_reg;
    logic [CNT_W-1:0]    byte_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            byte_cnt  <= '0;
        end else if (load) begin
            shift_reg <= word_in;
            byte_cnt  <= '0;
        end else if (shift) begin
            shift_reg <= shift_reg << BYTE_W;
            byte_cnt  <= byte_cnt + 1'b1;
        end
    end

    assign byte_out = shift_reg[LEN_DATA-1 -: BYTE_W];
    assign last     = (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/debug_mem_reader.sv
// Sweeps data memory after halt and streams every word to uart_tx, MSB byte first.
module debug_mem_reader
    import debug_mem_reader_pkg::*;
#(
    parameter int unsigned LEN_DATA  = 32,
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned NUM_WORDS = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_rd,
    input  logic [LEN_DATA-1:0] mem_data,
    output logic [BYTE_W-1:0]   tx_data,
    output logic                tx_start,
    input  logic                tx_done,
    output logic                busy,
    output logic                done
);

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic                mem_rd_d;
    logic                tx_start_d;
    logic                busy_d;
    logic                done_d;
    logic                ser_load;
    logic                ser_shift;
    logic                ser_last;

    word_byte_serializer #(
        .LEN_DATA(LEN_DATA)
    ) u_serializer (
        .clk     (clk),
        .reset   (reset),
        .load    (ser_load),
        .shift   (ser_shift),
        .word_in (mem_data),
        .byte_out(tx_data),
        .last    (ser_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            word_cnt_q <= '0;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            tx_start   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            mem_addr   <= mem_addr_d;
            mem_rd     <= mem_rd_d;
            tx_start   <= tx_start_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    // Outputs are registered, so each branch sets the values seen in the state being entered.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        mem_addr_d = mem_addr;
        mem_rd_d   = 1'b0;
        tx_start_d = 1'b0;
        busy_d     = busy;
        done_d     = 1'b0;
        ser_load   = 1'b0;
        ser_shift  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_READ;
                    word_cnt_d = '0;
                    mem_addr_d = '0;
                    mem_rd_d   = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            S_READ: begin
                ser_load   = 1'b1;
                tx_start_d = 1'b1;
                state_d    = S_SEND;
            end
            S_SEND: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done) begin
                    if (!ser_last) begin
                        ser_shift  = 1'b1;
                        tx_start_d = 1'b1;
                        state_d    = S_SEND;
                    end else if (word_cnt_q != LAST_WORD) begin
                        word_cnt_d = word_cnt_q + 1'b1;
                        mem_addr_d = mem_addr + 1'b1;
                        mem_rd_d   = 1'b1;
                        state_d    = S_READ;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                mem_addr_d = '0;
                word_cnt_d = '0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_debug_mem_reader.sv
// Scoreboard bench: a single-word instance and a full 64-word instance share clock and reset.
module tb_debug_mem_reader;

    typedef struct {
        logic [7:0] b;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    logic        reset;
    int          n_vec = 0;
    int          n_err = 0;

    // single-word instance
    logic        start_a, mem_rd_a, tx_start_a, tx_done_a, busy_a, done_a;
    logic [5:0]  mem_addr_a;
    logic [31:0] mem_data_a;
    logic [7:0]  tx_data_a;
    logic [31:0] mem_a [64];
    assign mem_data_a = mem_a[mem_addr_a];

    // full-sweep instance
    logic        start_b, mem_rd_b, tx_start_b, tx_done_b, busy_b, done_b;
    logic [5:0]  mem_addr_b;
    logic [31:0] mem_data_b;
    logic [7:0]  tx_data_b;
    logic [31:0] mem_b [64];
    assign mem_data_b = mem_b[mem_addr_b];

    debug_mem_reader #(.LEN_DATA(32), .ADDR_W(6), .NUM_WORDS(1)) u_one (
        .clk(clk), .reset(reset), .start(start_a), .mem_addr(mem_addr_a), .mem_rd(mem_rd_a),
        .mem_data(mem_data_a), .tx_data(tx_data_a), .tx_start(tx_start_a), .tx_done(tx_done_a),
        .busy(busy_a), .done(done_a)
    );

    debug_mem_reader #(.LEN_DATA(32), .ADDR_W(6), .NUM_WORDS(64)) u_dut (
        .clk(clk), .reset(reset), .start(start_b), .mem_addr(mem_addr_b), .mem_rd(mem_rd_b),
        .mem_data(mem_data_b), .tx_data(tx_data_b), .tx_start(tx_start_b), .tx_done(tx_done_b),
        .busy(busy_b), .done(done_b)
    );

    exp_t q_a[$];
    exp_t q_b[$];
    int   start_cyc_a = 0, start_cyc_b = 0;
    int   last_td_b = 0;
    int   done_cnt_a = 0, done_cnt_b = 0;
    int   sent_b = 0;
    int   busy_gap_b = 0;
    int   rd_cnt_b [64];
    int   dly_b = 3;
    bit   spur_b = 0, force_b = 0, sweeping_b = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // uart_tx stand-in for the single-word instance: tx_done 3 cycles after each tx_start
    initial begin : resp_a
        int pend;
        pend = 0;
        tx_done_a = 1'b0;
        forever begin
            @(negedge clk);
            tx_done_a = 1'b0;
            if (!reset) pend = 0;
            else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) tx_done_a = 1'b1;
                end
                if (tx_start_a) pend = 3;
            end
        end
    end

    // uart_tx stand-in for the sweep instance, plus optional spurious tx_done in READ/SEND/IDLE
    initial begin : resp_b
        int pend;
        pend = 0;
        tx_done_b = 1'b0;
        forever begin
            @(negedge clk);
            tx_done_b = 1'b0;
            if (!reset) pend = 0;
            else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        tx_done_b = 1'b1;
                        last_td_b = cycle;
                    end
                end
                if (tx_start_b) pend = dly_b;
                if (force_b || (spur_b && (tx_start_b || mem_rd_b))) tx_done_b = 1'b1;
            end
        end
    end

    initial begin : mon_a
        exp_t e;
        forever begin
            @(negedge clk);
            if (done_a) begin
                done_cnt_a++;
                chk("a_done_cycle", cycle - start_cyc_a, 18);
                chk("a_done_queue_empty", q_a.size(), 0);
            end
            if (tx_start_a) begin
                if (q_a.size() == 0) chk("a_tx_unexpected", tx_start_a, 0);
                else begin
                    e = q_a.pop_front();
                    chk("a_tx_data", tx_data_a, e.b);
                    chk("a_tx_cycle", cycle - start_cyc_a, e.cyc);
                end
            end
        end
    end

    initial begin : mon_b
        exp_t e;
        forever begin
            @(negedge clk);
            if (done_b) begin
                done_cnt_b++;
                sweeping_b = 0;
                chk("b_done_cycle", cycle, last_td_b + 1);
                chk("b_done_busy", busy_b, 0);
                chk("b_done_queue_empty", q_b.size(), 0);
            end
            if (sweeping_b && !busy_b) busy_gap_b++;
            if (mem_rd_b) rd_cnt_b[mem_addr_b]++;
            if (tx_start_b) begin
                sent_b++;
                if (q_b.size() == 0) chk("b_tx_unexpected", tx_start_b, 0);
                else begin
                    e = q_b.pop_front();
                    chk("b_tx_data", tx_data_b, e.b);
                    if (e.cyc >= 0) chk("b_tx_cycle", cycle - start_cyc_b, e.cyc);
                end
            end
        end
    end

    task automatic push_sweep_b(input bit timed, input int nbytes);
        exp_t e;
        int   k;
        int   cyc_tab [8];
        cyc_tab = '{2, 4, 6, 8, 11, 13, 15, 17};
        k = 0;
        for (int w = 0; w < 64; w++) begin
            for (int j = 3; j >= 0; j--) begin
                if (k < nbytes) begin
                    e.b   = mem_b[w][8*j +: 8];
                    e.cyc = (timed && k < 8) ? cyc_tab[k] : -1;
                    q_b.push_back(e);
                end
                k++;
            end
        end
    endtask

    task automatic clear_stats_b();
        sent_b     = 0;
        busy_gap_b = 0;
        for (int i = 0; i < 64; i++) rd_cnt_b[i] = 0;
    endtask

    task automatic start_sweep_b();
        @(negedge clk);
        start_b     = 1'b1;
        start_cyc_b = cycle;
        @(negedge clk);
        start_b    = 1'b0;
        sweeping_b = 1;
        chk("b_rd_after_start", mem_rd_b, 1);
        chk("b_addr_after_start", mem_addr_b, 0);
    endtask

    task automatic wait_done_b(input int target, input bit poke_start);
        int n;
        n = 0;
        while (done_cnt_b < target && n < 5000) begin
            @(negedge clk);
            n++;
            start_b = poke_start && (n % 37 == 0) && (sent_b < 250);
        end
        start_b = 1'b0;
        chk("b_sweep_done", done_cnt_b, target);
    endtask

    task automatic check_sweep_b();
        chk("b_tx_count", sent_b, 256);
        chk("b_busy_gaps", busy_gap_b, 0);
        for (int i = 0; i < 64; i++) chk("b_read_once", rd_cnt_b[i], 1);
        @(negedge clk);
        chk("b_idle_addr", mem_addr_b, 0);
        chk("b_idle_busy", busy_b, 0);
        chk("b_idle_done", done_b, 0);
        clear_stats_b();
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        exp_t e;
        int   n;
        int   tgt;
        reset   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = '0;
            mem_b[i] = i;
        end
        mem_a[0] = 32'hDEADBEEF;
        clear_stats_b();

        // reset held with start toggling
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start_a = i[0];
            start_b = i[0];
            chk("rst_mem_addr", mem_addr_b, 0);
            chk("rst_mem_rd", mem_rd_b, 0);
            chk("rst_tx_data", tx_data_b, 0);
            chk("rst_tx_start", tx_start_b, 0);
            chk("rst_busy", busy_b, 0);
            chk("rst_done", done_b, 0);
            chk("rst_a_tx_start", tx_start_a, 0);
        end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        reset   = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_busy", busy_b, 0);

        // single word DEADBEEF
        e.b = 8'hDE; e.cyc = 2;  q_a.push_back(e);
        e.b = 8'hAD; e.cyc = 6;  q_a.push_back(e);
        e.b = 8'hBE; e.cyc = 10; q_a.push_back(e);
        e.b = 8'hEF; e.cyc = 14; q_a.push_back(e);
        @(negedge clk);
        start_a     = 1'b1;
        start_cyc_a = cycle;
        @(negedge clk);
        start_a = 1'b0;
        chk("a_busy_after_start", busy_a, 1);
        n = 0;
        while (done_cnt_a < 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("a_sweep_done", done_cnt_a, 1);

        // stray tx_done while idle must not be remembered
        force_b = 1;
        repeat (2) @(negedge clk);
        force_b = 0;

        // full sweep mem[i]=i with spurious start and tx_done
        dly_b  = 3;
        spur_b = 1;
        push_sweep_b(0, 256);
        tgt = done_cnt_b + 1;
        start_sweep_b();
        wait_done_b(tgt, 1);
        spur_b = 0;
        check_sweep_b();

        // back-to-back tx_done
        mem_b[0] = 32'h1;
        mem_b[1] = 32'h2;
        dly_b    = 1;
        push_sweep_b(1, 256);
        tgt = done_cnt_b + 1;
        start_sweep_b();
        wait_done_b(tgt, 0);
        check_sweep_b();

        // reset after byte 2 of word 5, then restart from word 0
        mem_b[0] = 32'hA1B2C3D4;
        dly_b    = 3;
        push_sweep_b(0, 22);
        start_sweep_b();
        n = 0;
        while (sent_b < 22 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("b_abort_point", sent_b, 22);
        reset      = 1'b0;
        sweeping_b = 0;
        repeat (2) begin
            @(negedge clk);
            chk("b_midrst_busy", busy_b, 0);
            chk("b_midrst_addr", mem_addr_b, 0);
            chk("b_midrst_tx_start", tx_start_b, 0);
        end
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("b_queue_after_abort", q_b.size(), 0);
        clear_stats_b();
        dly_b = 1;
        push_sweep_b(1, 256);
        tgt = done_cnt_b + 1;
        start_sweep_b();
        wait_done_b(tgt, 0);
        check_sweep_b();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
